decode_out_fifo: RTL
====================

Name: decode_out_fifo

Overview:
- Downstream buffering stage for the decoder output: captures each valid decoded WIDTH-bit word and presents it to the consumer over a valid/ready handshake.
- Absorbs consumer back-pressure with a DEPTH-entry synchronous FIFO.
- Reports occupancy, full and empty status, and a sticky overflow flag for words dropped while full.

Parameters:
- WIDTH, 32, data word width; must match the decoder output width.
- DEPTH, 8, FIFO entries; power of 2, at least 2.
- AW, $clog2(DEPTH), pointer width; derived, never overridden.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  upstream word present this cycle.
- in_data  input  WIDTH  decoded word from decoder.
- in_ready  output  1  FIFO can accept a word; equals !full.
- out_valid  output  1  head word available; equals !empty.
- out_data  output  WIDTH  head-of-FIFO word.
- out_ready  input  1  consumer accepts head word.
- level  output  AW+1  current occupancy, 0..DEPTH.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.
- overflow  output  1  sticky; a word was offered while full.
- clr_ovf  input  1  clears overflow.

Behaviour:
- Reset, synchronous on rst=1 at a clock edge:
  - rd_ptr, wr_ptr and level go to 0.
  - empty=1, full=0, out_valid=0, in_ready=1, overflow=0.
  - out_data=0 while empty.
  - Storage array is not reset.
- Push: in_valid && in_ready at the edge writes in_data to mem[wr_ptr] and wraps wr_ptr modulo DEPTH.
- Pop: out_valid && out_ready at the edge advances rd_ptr modulo DEPTH.
- out_data: combinational read of mem[rd_ptr], forced to 0 when empty.
- Latency: a word pushed at edge N is visible on out_data/out_valid after edge N; first-word fall-through is one cycle.
- Occupancy at each edge:
  - push only: level+1.
  - pop only: level-1.
  - push and pop together: level unchanged, both pointers advance.
- in_ready depends only on registered full; there is no combinational path from out_ready to in_ready.
- Full: in_ready=0. A simultaneous pop frees a slot for the next cycle, not the current one.
- Full with in_valid=1: the word is dropped, storage is unchanged, and overflow is set at that edge.
- Empty with out_ready=1: no effect, pointers hold.
- Overflow flag:
  - set has priority over clr_ovf in the same cycle.
  - otherwise clr_ovf=1 clears it.
- Pointers wrap naturally at DEPTH-1 to 0; full and empty come from level, not pointer equality.
- Reset mid-operation: all contents are discarded and status returns to empty within that same edge.
- Data is not interpreted; all WIDTH bits pass through unchanged.

Optional Feature:
- Macro: DECODE_OUT_FIFO_STATS_EN.
- Defined:
  - Adds output drop_cnt [15:0], a saturating count of dropped words (full && in_valid).
  - Resets to 0 and is cleared by clr_ovf on the same priority rules as overflow: an increment wins over the clear in the same cycle.
  - Holds at 16'hFFFF once saturated.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: after rst, level=0, empty=1, in_ready=1, out_valid=0, out_data=0, overflow=0.
- Single word: push 11111110 (0x00A98AC6) with out_ready=0 -> next cycle out_valid=1, out_data=0x00A98AC6, level=1; pulse out_ready -> empty=1, level=0.
- Fill and order: push 8 words 11111110, 11111101, 11111011, 11110111, 11101111, 11011111, 10111111, 01111111 -> full=1, in_ready=0, level=8; drain with out_ready=1 -> words emerge in the same order, with wrap exercised by a second fill.
- Overflow: when full, hold in_valid=1 with data 11111111 for 3 cycles -> overflow=1, level stays 8, 11111111 never appears on out_data; with STATS_EN, drop_cnt=3; clr_ovf -> overflow=0, drop_cnt=0.
- Simultaneous push and pop at level 4: 6 consecutive cycles with in_valid=1 and out_ready=1 -> level stays 4 and output order is preserved; at level 8, push and pop together -> word dropped, level=7.
- Reset mid-stream: assert rst at level 5 -> next cycle level=0, empty=1, overflow=0, and subsequent pushes start from pointer 0.

Source files
------------

// File: rtl/decode_out_fifo.sv
// ---------------------------------------------------------------------------
// decode_out_fifo
//
// Downstream buffering stage for the decoder output. Each valid decoded word
// is captured into a DEPTH-entry synchronous FIFO and presented to the
// consumer over a valid/ready handshake. Words offered while the FIFO is
// full are dropped and recorded in a sticky overflow flag.
//
// Parameters:
//   WIDTH  data word width (must match the decoder output width)
//   DEPTH  FIFO entries, power of 2, >= 2
//   AW     pointer width, derived from DEPTH
//
// Ports:
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset
//   in_valid   upstream word present this cycle
//   in_data    decoded word from the decoder
//   in_ready   FIFO can accept a word (== !full)
//   out_valid  head word available (== !empty)
//   out_data   head-of-FIFO word, 0 while empty
//   out_ready  consumer accepts the head word
//   level      current occupancy, 0..DEPTH
//   full       level == DEPTH
//   empty      level == 0
//   overflow   sticky: a word was offered while full
//   clr_ovf    clears overflow (a new drop in the same cycle wins)
//   drop_cnt   (only with DECODE_OUT_FIFO_STATS_EN) saturating count of
//              dropped words, cleared by clr_ovf like overflow
//
// Optional feature macro: DECODE_OUT_FIFO_STATS_EN
// ---------------------------------------------------------------------------
module decode_out_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [AW:0]      level,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    input  logic             clr_ovf
`ifdef DECODE_OUT_FIFO_STATS_EN
    ,
    output logic [15:0]      drop_cnt
`endif
);

    localparam logic [AW:0] DEPTH_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q,  level_d;
    logic          overflow_q, overflow_d;

    logic push;
    logic pop;
    logic drop;

    // Status is derived from the registered occupancy only, so in_ready has
    // no combinational dependence on out_ready: a pop while full frees a
    // slot for the next cycle, not this one.
    assign full      = (level_q == DEPTH_LVL);
    assign empty     = (level_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign out_data  = empty ? '0 : mem[rd_ptr_q];

    always_comb begin
        push = in_valid && !full;
        pop  = out_ready && !empty;
        drop = in_valid && full;

        // Pointers wrap naturally because DEPTH is a power of 2.
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + (AW+1)'(push) - (AW+1)'(pop);

        // A drop in the same cycle as a clear keeps the flag set.
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage has no reset; stale contents are never visible because
    // out_data is masked while empty.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

`ifdef DECODE_OUT_FIFO_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    assign drop_cnt = drop_cnt_q;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end else if (clr_ovf) begin
            drop_cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= 16'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end
`endif

endmodule
